// File: rtl/pea_pkg.sv
// Shared types for the PE array configuration path.
// Holds the PE config word layout, array sizing constants and loader states.
package pea_pkg;

    localparam int PEA_M         = 4;
    localparam int PEA_N         = 4;
    localparam int PE_CFG_BITS   = 16;
    localparam int CFG_BUS_W     = 2 * PE_CFG_BITS;
    localparam int N_PE          = PEA_M * PEA_N;
    localparam int N_CFG_WORDS   = N_PE / 2;
    localparam int LOG_N_PE      = $clog2(N_PE);

    // FU opcode set; codes from 4'd13 upward are illegal.
    typedef enum logic [3:0] {
        FU_ADD = 4'd0,
        FU_SUB = 4'd1,
        FU_MUL = 4'd2,
        FU_AND = 4'd3,
        FU_OR  = 4'd4,
        FU_XOR = 4'd5,
        FU_SHL = 4'd6,
        FU_SHR = 4'd7,
        FU_SRA = 4'd8,
        FU_MIN = 4'd9,
        FU_MAX = 4'd10,
        FU_EQ  = 4'd11,
        FU_LT  = 4'd12
    } fu_instr_t;

    // Select 3'd7 has no source behind it.
    typedef enum logic [2:0] {
        SEL_STREAM_IN0 = 3'd0,
        SEL_STREAM_IN1 = 3'd1,
        SEL_NORTH      = 3'd2,
        SEL_SOUTH      = 3'd3,
        SEL_EAST       = 3'd4,
        SEL_WEST       = 3'd5,
        SEL_CONST      = 3'd6
    } pe_mux_sel_t;

    typedef struct packed {
        logic [4:0]  reserved;
        logic        out_reg_en;
        pe_mux_sel_t sel_b;
        pe_mux_sel_t sel_a;
        fu_instr_t   op;
    } pe_cfg_t;

    localparam logic [3:0] OP_FIRST_ILLEGAL = 4'b1101;
    localparam logic [2:0] SEL_ILLEGAL      = 3'b111;

    typedef enum logic [1:0] {
        LDR_IDLE  = 2'd0,
        LDR_LOAD  = 2'd1,
        LDR_READY = 2'd2
    } ldr_state_t;

endpackage

// File: rtl/pe_cfg_check.sv
// Combinational legality check of one PE configuration word.
// Ports: i_cfg (PE word), o_illegal (unsupported opcode or input select).
module pe_cfg_check
    import pea_pkg::*;
(
    input  pe_cfg_t i_cfg,
    output logic    o_illegal
);

    logic [3:0] w_op;
    logic [2:0] w_sel_a;
    logic [2:0] w_sel_b;
    logic [5:0] w_unused_bits;

    assign w_op    = i_cfg.op;
    assign w_sel_a = i_cfg.sel_a;
    assign w_sel_b = i_cfg.sel_b;

    // Reserved bits and the output register enable never make a word illegal.
    assign w_unused_bits = {i_cfg.reserved, i_cfg.out_reg_en};

    assign o_illegal = (w_op >= OP_FIRST_ILLEGAL)
                     | (w_sel_a == SEL_ILLEGAL)
                     | (w_sel_b == SEL_ILLEGAL);

endmodule

// File: rtl/pea_cfg_loader.sv
// Streams per-PE config words into a shadow bank and commits them to the
// active bank in one cycle, flagging the first illegal PE word of a load.
// Ports: clk_i/rst_i, start_i, cfg_valid_i/cfg_data_i/cfg_ready_o,
// loaded_o, commit_i/commit_ack_o, err_o/err_pe_idx_o, pe_cfg_o (active bank).
module pea_cfg_loader
    import pea_pkg::*;
#(
    parameter int M             = 4,
    parameter int N             = 4,
    parameter int N_CFG_BITS_PE = 16,
    parameter int BUS_W         = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic                            cfg_valid_i,
    input  logic [BUS_W-1:0]                cfg_data_i,
    output logic                            cfg_ready_o,
    output logic                            loaded_o,
    input  logic                            commit_i,
    output logic                            commit_ack_o,
    output logic                            err_o,
    output logic [$clog2(M*N)-1:0]          err_pe_idx_o,
    output logic [M*N*N_CFG_BITS_PE-1:0]    pe_cfg_o
);

    localparam int L_N_PE  = M * N;
    localparam int L_WORDS = L_N_PE / 2;
    localparam int IDX_W   = $clog2(L_N_PE);
    localparam int PTR_W   = (L_WORDS > 1) ? $clog2(L_WORDS) : 1;
    localparam int CFG_W   = L_N_PE * N_CFG_BITS_PE;

    ldr_state_t        r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [CFG_W-1:0]  r_shadow;
    logic [CFG_W-1:0]  r_active;
    logic              r_cfg_ready;
    logic              r_loaded;
    logic              r_ack;
    logic              r_err;
    logic [IDX_W-1:0]  r_err_idx;

    pe_cfg_t           w_cfg_lo;
    pe_cfg_t           w_cfg_hi;
    logic              w_ill_lo;
    logic              w_ill_hi;
    logic              w_last;
    logic [IDX_W-1:0]  w_idx_even;
    logic [IDX_W-1:0]  w_idx_odd;

    assign w_cfg_lo = pe_cfg_t'(cfg_data_i[N_CFG_BITS_PE-1:0]);
    assign w_cfg_hi = pe_cfg_t'(cfg_data_i[BUS_W-1:N_CFG_BITS_PE]);

    pe_cfg_check u_chk_lo (
        .i_cfg     (w_cfg_lo),
        .o_illegal (w_ill_lo)
    );

    pe_cfg_check u_chk_hi (
        .i_cfg     (w_cfg_hi),
        .o_illegal (w_ill_hi)
    );

    assign w_last     = (r_ptr == PTR_W'(L_WORDS - 1));
    assign w_idx_even = IDX_W'({r_ptr, 1'b0});
    assign w_idx_odd  = IDX_W'({r_ptr, 1'b1});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= LDR_IDLE;
            r_ptr       <= '0;
            r_shadow    <= '0;
            r_active    <= '0;
            r_cfg_ready <= 1'b0;
            r_loaded    <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_err_idx   <= '0;
        end else begin
            r_ack <= 1'b0;
            unique case (r_state)
                LDR_IDLE: begin
                    if (start_i) begin
                        r_state     <= LDR_LOAD;
                        r_ptr       <= '0;
                        r_err       <= 1'b0;
                        r_err_idx   <= '0;
                        r_cfg_ready <= 1'b1;
                    end
                end
                LDR_LOAD: begin
                    // A restart drops any word offered in the same cycle.
                    if (start_i) begin
                        r_ptr     <= '0;
                        r_err     <= 1'b0;
                        r_err_idx <= '0;
                    end else if (cfg_valid_i) begin
                        r_shadow[r_ptr*BUS_W +: BUS_W] <= cfg_data_i;
                        r_ptr <= r_ptr + PTR_W'(1);
                        // Only the first offender of a load is recorded;
                        // the even half wins when both are bad.
                        if (!r_err && (w_ill_lo || w_ill_hi)) begin
                            r_err     <= 1'b1;
                            r_err_idx <= w_ill_lo ? w_idx_even : w_idx_odd;
                        end
                        if (w_last) begin
                            r_state     <= LDR_READY;
                            r_cfg_ready <= 1'b0;
                            r_loaded    <= 1'b1;
                        end
                    end
                end
                LDR_READY: begin
                    if (start_i) begin
                        r_state     <= LDR_LOAD;
                        r_ptr       <= '0;
                        r_err       <= 1'b0;
                        r_err_idx   <= '0;
                        r_cfg_ready <= 1'b1;
                        r_loaded    <= 1'b0;
                    end else if (commit_i) begin
                        // A faulty load is discarded; err stays visible.
                        if (!r_err) begin
                            r_active <= r_shadow;
                            r_ack    <= 1'b1;
                        end
                        r_state  <= LDR_IDLE;
                        r_loaded <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= LDR_IDLE;
                    r_cfg_ready <= 1'b0;
                    r_loaded    <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready_o  = r_cfg_ready;
    assign loaded_o     = r_loaded;
    assign commit_ack_o = r_ack;
    assign err_o        = r_err;
    assign err_pe_idx_o = r_err_idx;
    assign pe_cfg_o     = r_active;

endmodule

// File: tb/tb_pea_cfg_loader.sv
// Randomised scoreboard bench for pea_cfg_loader.
// Commits push expected banks; a negedge monitor checks acks and pe_cfg_o.
module tb_pea_cfg_loader;

    localparam int NPE = 16;
    localparam int NW  = 8;
    localparam int CW  = 256;

    typedef logic [15:0] pe_arr_t [NPE];

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            start_i = 1'b0;
    logic            cfg_valid_i = 1'b0;
    logic [31:0]     cfg_data_i = '0;
    logic            cfg_ready_o;
    logic            loaded_o;
    logic            commit_i = 1'b0;
    logic            commit_ack_o;
    logic            err_o;
    logic [3:0]      err_pe_idx_o;
    logic [CW-1:0]   pe_cfg_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] cur_bank = '0;
    logic          rst_q = 1'b0;

    always #5 clk = ~clk;

    pea_cfg_loader #(
        .M(4), .N(4), .N_CFG_BITS_PE(16), .BUS_W(32)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_data_i   (cfg_data_i),
        .cfg_ready_o  (cfg_ready_o),
        .loaded_o     (loaded_o),
        .commit_i     (commit_i),
        .commit_ack_o (commit_ack_o),
        .err_o        (err_o),
        .err_pe_idx_o (err_pe_idx_o),
        .pe_cfg_o     (pe_cfg_o)
    );

    task automatic check(input string name, input logic [CW-1:0] act,
                         input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: active bank only moves on an ack; reset zeroes it.
    always @(posedge clk) rst_q <= rst_i;

    always @(negedge clk) begin
        if (rst_q) begin
            cur_bank = '0;
            exp_q.delete();
        end
        if (commit_ack_o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack: commit_ack_o=1 expected 0");
            end else begin
                cur_bank = exp_q.pop_front();
            end
        end
        check("pe_cfg_o", pe_cfg_o, cur_bank);
    end

    function automatic bit is_bad(input logic [15:0] w);
        return (w[3:0] >= 4'd13) || (w[6:4] == 3'd7) || (w[9:7] == 3'd7);
    endfunction

    function automatic int first_bad(input pe_arr_t pe);
        for (int i = 0; i < NPE; i++)
            if (is_bad(pe[i])) return i;
        return -1;
    endfunction

    function automatic logic [CW-1:0] pack(input pe_arr_t pe);
        logic [CW-1:0] b;
        b = '0;
        for (int i = 0; i < NPE; i++) b[16*i +: 16] = pe[i];
        return b;
    endfunction

    function automatic logic [15:0] rand_word(input bit legal);
        logic [15:0] w;
        w = 16'($urandom);
        if (legal) begin
            w[3:0] = 4'($urandom_range(0, 12));
            w[6:4] = 3'($urandom_range(0, 6));
            w[9:7] = 3'($urandom_range(0, 6));
        end
        return w;
    endfunction

    task automatic load(input pe_arr_t pe, input int gap_pct,
                        input bit do_start, input int n_words,
                        input string tag);
        int hs;
        int cyc;
        int fb;
        bit hs_now;
        hs  = 0;
        cyc = 0;
        if (do_start) begin
            start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
            check({tag, "_ready_on_start"}, CW'(cfg_ready_o), CW'(1'b1));
            check({tag, "_loaded_on_start"}, CW'(loaded_o), CW'(1'b0));
            check({tag, "_err_cleared"}, CW'(err_o), CW'(1'b0));
            check({tag, "_idx_cleared"}, CW'(err_pe_idx_o), CW'(4'd0));
        end
        while (hs < n_words && cyc < 400) begin
            cfg_valid_i = ($urandom_range(0, 99) >= gap_pct);
            cfg_data_i  = {pe[2*hs+1], pe[2*hs]};
            if (cfg_valid_i)
                check({tag, "_ready_in_load"}, CW'(cfg_ready_o), CW'(1'b1));
            hs_now = cfg_valid_i && cfg_ready_o;
            @(posedge clk); #1;
            cyc++;
            if (hs_now) hs++;
            if (hs < NW)
                check({tag, "_loaded_early"}, CW'(loaded_o), CW'(1'b0));
        end
        cfg_valid_i = 1'b0;
        if (hs < n_words) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_load_timeout: got %0d handshakes expected %0d",
                     tag, hs, n_words);
        end
        if (n_words == NW) begin
            fb = first_bad(pe);
            check({tag, "_loaded"}, CW'(loaded_o), CW'(1'b1));
            check({tag, "_ready_done"}, CW'(cfg_ready_o), CW'(1'b0));
            check({tag, "_err"}, CW'(err_o), CW'(fb >= 0));
            check({tag, "_err_idx"}, CW'(err_pe_idx_o),
                  CW'((fb >= 0) ? fb : 0));
        end
    endtask

    task automatic do_commit(input bit exp_ack, input logic [CW-1:0] bank);
        commit_i = 1'b1;
        if (exp_ack) exp_q.push_back(bank);
        @(posedge clk); #1;
        commit_i = 1'b0;
        check("commit_loaded", CW'(loaded_o), CW'(1'b0));
        check("commit_ready", CW'(cfg_ready_o), CW'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        check("ack_missing", CW'(exp_q.size()), CW'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pe_arr_t base;
        pe_arr_t bad;
        pe_arr_t p;
        int      fb;

        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        check("rst_ready", CW'(cfg_ready_o), CW'(1'b0));
        check("rst_loaded", CW'(loaded_o), CW'(1'b0));
        check("rst_ack", CW'(commit_ack_o), CW'(1'b0));
        check("rst_err", CW'(err_o), CW'(1'b0));
        check("rst_idx", CW'(err_pe_idx_o), CW'(4'd0));
        repeat (3) @(posedge clk);
        #1;

        // Legal pattern with PE index in the reserved field.
        for (int i = 0; i < NPE; i++)
            base[i] = 16'(i << 11) | 16'(i % 13) | ((i % 2 == 1) ? 16'h0400 : 16'h0);
        load(base, 0, 1'b1, NW, "s1");
        do_commit(1'b1, pack(base));

        // Illegal opcode in PE 7 (word 3, high half).
        bad = base;
        bad[7][3:0] = 4'hE;
        load(bad, 0, 1'b1, NW, "s2");
        do_commit(1'b0, '0);
        check("s2_err_hold", CW'(err_o), CW'(1'b1));
        check("s2_idx_hold", CW'(err_pe_idx_o), CW'(4'd7));
        repeat (4) @(posedge clk);
        #1;
        check("s2_err_sticky", CW'(err_o), CW'(1'b1));
        do_commit(1'b0, '0);

        // Both halves of word 2 bad plus a later offender: even index wins.
        bad = base;
        bad[4][6:4]  = 3'd7;
        bad[5][9:7]  = 3'd7;
        bad[11][3:0] = 4'd13;
        load(bad, 30, 1'b1, NW, "s2b");
        do_commit(1'b0, '0);

        // Random words with ~50% valid gaps.
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < NPE; i++)
                p[i] = rand_word($urandom_range(0, 15) != 0);
            fb = first_bad(p);
            load(p, 50, 1'b1, NW, "s3");
            do_commit(fb < 0, pack(p));
        end

        // Restart after 5 words; commit during LOAD is ignored.
        for (int i = 0; i < NPE; i++) p[i] = rand_word(1'b1);
        load(p, 0, 1'b1, 5, "s4a");
        commit_i = 1'b1;
        @(posedge clk); #1;
        commit_i = 1'b0;
        check("s4_ready_after_commit", CW'(cfg_ready_o), CW'(1'b1));
        for (int i = 0; i < NPE; i++) p[i] = rand_word(1'b1);
        load(p, 0, 1'b1, NW, "s4b");
        do_commit(1'b1, pack(p));

        // start+commit in READY, then start coincident with a handshake.
        for (int i = 0; i < NPE; i++) p[i] = rand_word(1'b1);
        load(p, 0, 1'b1, NW, "s5a");
        start_i  = 1'b1;
        commit_i = 1'b1;
        @(posedge clk); #1;
        start_i  = 1'b0;
        commit_i = 1'b0;
        check("s5_restart_ready", CW'(cfg_ready_o), CW'(1'b1));
        check("s5_restart_loaded", CW'(loaded_o), CW'(1'b0));
        start_i     = 1'b1;
        cfg_valid_i = 1'b1;
        cfg_data_i  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start_i     = 1'b0;
        cfg_valid_i = 1'b0;
        check("s5_drop_ready", CW'(cfg_ready_o), CW'(1'b1));
        check("s5_drop_err", CW'(err_o), CW'(1'b0));
        for (int i = 0; i < NPE; i++) p[i] = rand_word(1'b1);
        load(p, 40, 1'b0, NW, "s5b");
        do_commit(1'b1, pack(p));

        // Reset while READY: the load never reaches the active bank.
        for (int i = 0; i < NPE; i++) p[i] = rand_word(1'b1);
        load(p, 0, 1'b1, NW, "s6");
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        check("s6_rst_loaded", CW'(loaded_o), CW'(1'b0));
        check("s6_rst_ready", CW'(cfg_ready_o), CW'(1'b0));
        check("s6_rst_err", CW'(err_o), CW'(1'b0));
        do_commit(1'b0, '0);

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", CW'(exp_q.size()), CW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
